// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle SLL/SRL/SRA/PASS unit shifting STEP bits per clock.
// Ports: i_clk/i_reset(async, active-high)/i_flush; request i_valid/o_ready with i_op, i_data, i_shamt;
// response o_valid/i_ready with o_result; o_busy high while shifting or holding a result.
module iter_shift_unit #(
  parameter int STEP = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shamt,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [4:0] STEP5 = 5'(STEP);
  state_t      state_q;
  logic [31:0] data_q;
  logic [4:0]  rem_q;
  logic [1:0]  op_q;
  logic        valid_q;
  logic [4:0]  k;
  logic [4:0]  rem_nx;
  logic [31:0] sra;
  logic [31:0] shifted;
  always_comb begin
    k = (rem_q < STEP5) ? rem_q : STEP5;
    rem_nx = rem_q - k;
    // Sign bit never changes across stages, so extending the current word is exact.
    sra = 32'({{32{data_q[31]}}, data_q} >> k);
    shifted = (op_q == 2'b00) ? data_q << k : (op_q == 2'b01) ? data_q >> k : sra;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      data_q <= '0;
      rem_q <= '0;
      op_q <= '0;
      valid_q <= 1'b0;
    end else if (i_flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          data_q <= i_data;
          op_q <= i_op;
          rem_q <= i_shamt;
          if (i_shamt == 5'd0 || i_op == 2'b11) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end else begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          data_q <= shifted;
          rem_q <= rem_nx;
          if (rem_nx == 5'd0) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: if (i_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_ready = state_q == IDLE;
  assign o_busy = state_q != IDLE;
  assign o_valid = valid_q;
  assign o_result = data_q;
endmodule

// File: tb/tb_iter_shift_unit.sv
// tb_iter_shift_unit: randomized self-checking bench for iter_shift_unit at STEP=4 and STEP=1.
module tb_iter_shift_unit;
  logic        i_clk = 0, i_reset = 1, i_flush = 0, i_valid = 0, i_ready = 0;
  logic [1:0]  i_op = 0;
  logic [31:0] i_data = 0;
  logic [4:0]  i_shamt = 0;
  logic        sel = 0;
  logic        r4, v4, b4, r1, v1, b1;
  logic [31:0] res4, res1;
  logic        o_ready, o_valid, o_busy;
  logic [31:0] o_result;
  int          pass_cnt = 0, total = 0;

  iter_shift_unit #(.STEP(4)) u4 (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid & ~sel), .o_ready(r4),
    .i_op(i_op), .i_data(i_data), .i_shamt(i_shamt), .o_valid(v4), .i_ready(i_ready & ~sel),
    .o_result(res4), .o_busy(b4));
  iter_shift_unit #(.STEP(1)) u1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid & sel), .o_ready(r1),
    .i_op(i_op), .i_data(i_data), .i_shamt(i_shamt), .o_valid(v1), .i_ready(i_ready & sel),
    .o_result(res1), .o_busy(b1));

  assign o_ready = sel ? r1 : r4;
  assign o_valid = sel ? v1 : v4;
  assign o_busy = sel ? b1 : b4;
  assign o_result = sel ? res1 : res4;

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    logic signed [31:0] t;
    t = $signed(d);
    case (op)
      2'd0: return d << s;
      2'd1: return d >> s;
      2'd2: return t >>> s;
      default: return d;
    endcase
  endfunction

  function automatic int lat_model(input logic [1:0] op, input logic [4:0] s, input int step);
    return (op == 2'd3 || s == 0) ? 1 : (int'(s) + step - 1) / step + 1;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                        output logic [31:0] r, output int lat);
    i_op = op; i_data = d; i_shamt = s; i_valid = 1;
    @(posedge i_clk); #1;
    i_valid = 0; i_op = 2'($urandom); i_data = $urandom; i_shamt = 5'($urandom);
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(posedge i_clk); #1;
      lat++;
    end
    r = o_result;
  endtask

  task automatic release_out;
    i_ready = 1;
    @(posedge i_clk); #1;
    i_ready = 0;
  endtask

  task automatic test_reset;
    #2;
    total++; if (o_valid !== 1'b0 || o_result !== 32'h0 || o_busy !== 1'b0)
      $display("FAIL reset_state valid=%b result=%h busy=%b want 0/0/0", o_valid, o_result, o_busy);
    else pass_cnt++;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_reset = 0;
    @(posedge i_clk); #1;
    total++; if (o_ready !== 1'b1) $display("FAIL reset_ready got=%b want 1", o_ready); else pass_cnt++;
  endtask

  task automatic test_basic;
    logic [1:0] ops [3] = '{2'd2, 2'd1, 2'd0};
    logic [31:0] ds [3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001};
    logic [4:0] ss [3] = '{5'd31, 5'd4, 5'd0};
    logic [31:0] exp_r [3] = '{32'hFFFF_FFFF, 32'h0800_0000, 32'h0000_0001};
    int exp_l [3] = '{9, 2, 1};
    logic [31:0] r;
    int lat;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], ds[i], ss[i], r, lat);
      total++; if (r !== exp_r[i]) $display("FAIL basic_result[%0d] got=%h want=%h", i, r, exp_r[i]); else pass_cnt++;
      total++; if (lat != exp_l[i]) $display("FAIL basic_latency[%0d] got=%0d want=%0d", i, lat, exp_l[i]); else pass_cnt++;
      release_out();
      total++; if (o_ready !== 1'b1 || o_valid !== 1'b0)
        $display("FAIL basic_release[%0d] ready=%b valid=%b want 1/0", i, o_ready, o_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d, r, e;
    int lat;
    sel = 0;
    d = $urandom | 32'h8000_0000;
    e = model(2'd2, d, 5'd13);
    run_op(2'd2, d, 5'd13, r, lat);
    total++; if (r !== e) $display("FAIL bp_result got=%h want=%h", r, e); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin i_valid = 1; i_op = 2'd0; i_data = 32'h1234_5678; i_shamt = 5'd3; end
      @(posedge i_clk); #1;
      i_valid = 0;
      total++; if (o_result !== e || o_valid !== 1'b1 || o_ready !== 1'b0)
        $display("FAIL bp_hold[%0d] result=%h valid=%b ready=%b want %h/1/0", i, o_result, o_valid, o_ready, e);
      else pass_cnt++;
    end
    release_out();
    total++; if (o_ready !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL bp_release ready=%b valid=%b want 1/0", o_ready, o_valid);
    else pass_cnt++;
    repeat (2) @(posedge i_clk); #1;
    total++; if (o_busy !== 1'b0 || o_valid !== 1'b0)
      $display("FAIL bp_pulse_ignored busy=%b valid=%b want 0/0", o_busy, o_valid);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    logic [31:0] d, r, e;
    int lat;
    sel = 0;
    i_op = 2'd2; i_data = 32'hF000_0000; i_shamt = 5'd20; i_valid = 1;
    @(posedge i_clk); #1;
    i_valid = 0;
    @(posedge i_clk); #3;
    i_reset = 1;
    #1;
    total++; if (o_valid !== 1'b0 || o_result !== 32'h0 || o_busy !== 1'b0)
      $display("FAIL async_reset valid=%b result=%h busy=%b want 0/0/0", o_valid, o_result, o_busy);
    else pass_cnt++;
    @(negedge i_clk) i_reset = 0;
    #1;
    total++; if (o_ready !== 1'b1) $display("FAIL async_reset_ready got=%b want 1", o_ready); else pass_cnt++;
    d = $urandom;
    e = model(2'd2, d, 5'd17);
    run_op(2'd2, d, 5'd17, r, lat);
    total++; if (r !== e) $display("FAIL post_reset_op got=%h want=%h", r, e); else pass_cnt++;
    release_out();
  endtask

  task automatic test_flush;
    logic seen;
    logic [31:0] d, r, e;
    int lat;
    sel = 0;
    i_op = 2'd1; i_data = $urandom; i_shamt = 5'd20; i_valid = 1;
    @(posedge i_clk); #1;
    i_valid = 0;
    @(posedge i_clk); #1;
    i_flush = 1;
    @(posedge i_clk); #1;
    i_flush = 0;
    total++; if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0)
      $display("FAIL flush_shift ready=%b busy=%b valid=%b want 1/0/0", o_ready, o_busy, o_valid);
    else pass_cnt++;
    seen = 0;
    repeat (8) begin
      @(posedge i_clk); #1;
      seen |= o_valid;
    end
    total++; if (seen !== 1'b0) $display("FAIL flush_no_valid got=%b want 0", seen); else pass_cnt++;
    i_flush = 1; i_valid = 1; i_op = 2'd3; i_data = 32'hDEAD_BEEF;
    @(posedge i_clk); #1;
    i_flush = 0; i_valid = 0;
    total++; if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL flush_wins busy=%b ready=%b valid=%b want 0/1/0", o_busy, o_ready, o_valid);
    else pass_cnt++;
    d = $urandom;
    e = model(2'd0, d, 5'd9);
    run_op(2'd0, d, 5'd9, r, lat);
    total++; if (r !== e) $display("FAIL post_flush_op got=%h want=%h", r, e); else pass_cnt++;
    release_out();
  endtask

  task automatic test_step1;
    logic [31:0] r;
    int lat;
    sel = 1;
    run_op(2'd2, 32'hF000_0000, 5'd5, r, lat);
    total++; if (r !== 32'hFF80_0000) $display("FAIL step1_result got=%h want=ff800000", r); else pass_cnt++;
    total++; if (lat != 6) $display("FAIL step1_latency got=%0d want=6", lat); else pass_cnt++;
    release_out();
    sel = 0;
  endtask

  task automatic test_random;
    logic [1:0] op;
    logic [31:0] d, r, e;
    logic [4:0] s;
    int lat, el;
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom);
      op = 2'($urandom); d = $urandom; s = 5'($urandom);
      e = model(op, d, s);
      el = lat_model(op, s, sel ? 1 : 4);
      run_op(op, d, s, r, lat);
      total++; if (r !== e) $display("FAIL rand_result[%0d] op=%0d d=%h s=%0d got=%h want=%h", i, op, d, s, r, e); else pass_cnt++;
      total++; if (lat != el) $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, el); else pass_cnt++;
      release_out();
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_async_reset();
    test_flush();
    test_step1();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
